// File: rtl/collision_pkg.sv
// Shared types and constants for the brick collision tracker.
package collision_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      REPORT = 2'd2
   } coll_state_t;

   localparam int DEF_SCREEN_W = 640;
   localparam int DEF_SCREEN_H = 480;

   localparam logic [7:0] HIT_COUNT_MAX = 8'd255;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == HIT_COUNT_MAX) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/lowest_index_enc.sv
// Priority encoder: index of the lowest set bit plus a valid flag.
module lowest_index_enc #(
   parameter int N = 8,
   parameter int W = 3
) (
   input  logic [N-1:0] i_vec,
   output logic [W-1:0] o_idx,
   output logic         o_valid
);

   always_comb begin
      o_idx   = '0;
      o_valid = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (i_vec[i]) begin
            o_idx   = W'(i);
            o_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/brick_collision_tracker.sv
// Per-frame tank/shell vs brick overlap tracker; owns the live-brick mask
// and reports hits once per frame right after startOfFrame.
module brick_collision_tracker
   import collision_pkg::*;
#(
   parameter int N_BRICKS = 8,
   parameter int SCREEN_W = DEF_SCREEN_W,
   parameter int SCREEN_H = DEF_SCREEN_H,
   localparam int IW = idx_width(N_BRICKS)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                startOfFrame,
   input  logic                levelRestart,
   input  logic [10:0]         pixelX,
   input  logic [10:0]         pixelY,
   input  logic                tankDrawingRequest,
   input  logic                shellDrawingRequest,
   input  logic [N_BRICKS-1:0] brickDrawingRequest,
   output logic                tankHitBrick,
   output logic                shellHitBrick,
   output logic [IW-1:0]       hitBrickIdx,
   output logic [N_BRICKS-1:0] brickAlive,
   output logic [7:0]          hitCount
);

   localparam logic [10:0] X_LIM = 11'(SCREEN_W);
   localparam logic [10:0] Y_LIM = 11'(SCREEN_H);

   coll_state_t r_state;
   coll_state_t w_next;

   logic                r_tank_flag;
   logic                r_shell_flag;
   logic [IW-1:0]       r_shell_idx;
   logic [10:0]         r_px_d;
   logic [10:0]         r_py_d;
   logic                r_tank_pulse;
   logic                r_shell_pulse;
   logic [IW-1:0]       r_hit_idx;
   logic [N_BRICKS-1:0] r_alive;
   logic [7:0]          r_count;

   logic                w_scan;
   logic                w_report;
   logic                w_fire;
   logic                w_active;
   logic [N_BRICKS-1:0] w_live_hit;
   logic                w_any_live;
   logic [IW-1:0]       w_low_idx;
   logic                w_tank_set;
   logic                w_shell_set;

   // State register
   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    if (startOfFrame) w_next = SCAN;
         SCAN:    if (startOfFrame) w_next = REPORT;
         REPORT:  w_next = SCAN;
         default: w_next = IDLE;
      endcase
   end

   // State decode
   always_comb begin
      w_scan   = 1'b0;
      w_report = 1'b0;
      unique case (r_state)
         SCAN:    w_scan   = 1'b1;
         REPORT:  w_report = 1'b1;
         default: ;
      endcase
   end

   assign w_fire = w_scan & startOfFrame;

   // Coordinates lag one cycle to line up with the drawing requests
   always_ff @(posedge clk) begin
      if (reset) begin
         r_px_d <= '0;
         r_py_d <= '0;
      end else begin
         r_px_d <= pixelX;
         r_py_d <= pixelY;
      end
   end

   assign w_active   = (r_px_d < X_LIM) && (r_py_d < Y_LIM);
   assign w_live_hit = brickDrawingRequest & r_alive;

   lowest_index_enc #(
      .N (N_BRICKS),
      .W (IW)
   ) u_enc (
      .i_vec   (w_live_hit),
      .o_idx   (w_low_idx),
      .o_valid (w_any_live)
   );

   assign w_tank_set  = w_active & tankDrawingRequest & w_any_live;
   assign w_shell_set = w_active & shellDrawingRequest & w_any_live;

   // Accumulators live only in SCAN; any other state clears them
   always_ff @(posedge clk) begin
      if (reset) begin
         r_tank_flag  <= 1'b0;
         r_shell_flag <= 1'b0;
         r_shell_idx  <= '0;
      end else if (w_scan) begin
         if (w_tank_set) r_tank_flag <= 1'b1;
         if (w_shell_set && !r_shell_flag) begin
            r_shell_flag <= 1'b1;
            r_shell_idx  <= w_low_idx;
         end
      end else begin
         r_tank_flag  <= 1'b0;
         r_shell_flag <= 1'b0;
         r_shell_idx  <= '0;
      end
   end

   // Pulses are registered so they occupy exactly the REPORT cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         r_tank_pulse  <= 1'b0;
         r_shell_pulse <= 1'b0;
      end else begin
         r_tank_pulse  <= w_fire & r_tank_flag;
         r_shell_pulse <= w_fire & r_shell_flag;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_hit_idx <= '0;
      end else if (w_report && r_shell_flag) begin
         r_hit_idx <= r_shell_idx;
      end
   end

   // Restore beats the REPORT-cycle kill/increment
   always_ff @(posedge clk) begin
      if (reset) begin
         r_alive <= '1;
         r_count <= '0;
      end else if (levelRestart) begin
         r_alive <= '1;
         r_count <= '0;
      end else if (w_report && r_shell_flag) begin
         r_alive[r_shell_idx] <= 1'b0;
         r_count              <= sat_inc(r_count);
      end
   end

   assign tankHitBrick  = r_tank_pulse;
   assign shellHitBrick = r_shell_pulse;
   assign hitBrickIdx   = r_hit_idx;
   assign brickAlive    = r_alive;
   assign hitCount      = r_count;

endmodule

// File: tb/tb_brick_collision_tracker.sv
// Directed self-checking bench for brick_collision_tracker.
module tb_brick_collision_tracker;

   logic       clk = 1'b0;
   logic       reset;
   logic       startOfFrame;
   logic       levelRestart;
   logic [10:0] pixelX;
   logic [10:0] pixelY;
   logic       tankDrawingRequest;
   logic       shellDrawingRequest;
   logic [7:0] brickDrawingRequest;
   logic       tankHitBrick;
   logic       shellHitBrick;
   logic [2:0] hitBrickIdx;
   logic [7:0] brickAlive;
   logic [7:0] hitCount;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   brick_collision_tracker #(
      .N_BRICKS (8),
      .SCREEN_W (640),
      .SCREEN_H (480)
   ) dut (
      .clk                 (clk),
      .reset               (reset),
      .startOfFrame        (startOfFrame),
      .levelRestart        (levelRestart),
      .pixelX              (pixelX),
      .pixelY              (pixelY),
      .tankDrawingRequest  (tankDrawingRequest),
      .shellDrawingRequest (shellDrawingRequest),
      .brickDrawingRequest (brickDrawingRequest),
      .tankHitBrick        (tankHitBrick),
      .shellHitBrick       (shellHitBrick),
      .hitBrickIdx         (hitBrickIdx),
      .brickAlive          (brickAlive),
      .hitCount            (hitCount)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present pixel (x,y); requests follow one cycle later
   task automatic pix(input logic [10:0] x, input logic [10:0] y,
                      input logic t, input logic s,
                      input logic [7:0] b);
      pixelX = x;
      pixelY = y;
      tick();
      pixelX = 11'd0;
      pixelY = 11'd0;
      tankDrawingRequest  = t;
      shellDrawingRequest = s;
      brickDrawingRequest = b;
      tick();
      tankDrawingRequest  = 1'b0;
      shellDrawingRequest = 1'b0;
      brickDrawingRequest = 8'h00;
      tick();
   endtask

   task automatic sof();
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      startOfFrame = 1'b0;
      levelRestart = 1'b0;
      pixelX = 11'd0;
      pixelY = 11'd0;
      tankDrawingRequest = 1'b0;
      shellDrawingRequest = 1'b0;
      brickDrawingRequest = 8'h00;
      tick();
      tick();
      reset = 1'b0;
      tick();

      chk("rst_tank", 32'(tankHitBrick), 32'd0);
      chk("rst_shell", 32'(shellHitBrick), 32'd0);
      chk("rst_alive", 32'(brickAlive), 32'hFF);
      chk("rst_count", 32'(hitCount), 32'd0);
      chk("rst_idx", 32'(hitBrickIdx), 32'd0);

      // Empty frame
      sof();
      tick();
      tick();
      sof();
      chk("empty_tank", 32'(tankHitBrick), 32'd0);
      chk("empty_shell", 32'(shellHitBrick), 32'd0);
      tick();
      chk("empty_alive", 32'(brickAlive), 32'hFF);
      chk("empty_count", 32'(hitCount), 32'd0);

      // Tank on brick 3
      pix(11'd100, 11'd50, 1'b1, 1'b0, 8'h08);
      sof();
      chk("tank_pulse", 32'(tankHitBrick), 32'd1);
      chk("tank_noshell", 32'(shellHitBrick), 32'd0);
      tick();
      chk("tank_pulse_end", 32'(tankHitBrick), 32'd0);
      chk("tank_alive", 32'(brickAlive), 32'hFF);
      chk("tank_count", 32'(hitCount), 32'd0);

      // Shell on bricks 2 and 5 at one pixel
      pix(11'd200, 11'd60, 1'b0, 1'b1, 8'h24);
      sof();
      chk("shell_pulse", 32'(shellHitBrick), 32'd1);
      chk("shell_notank", 32'(tankHitBrick), 32'd0);
      tick();
      chk("shell_pulse_end", 32'(shellHitBrick), 32'd0);
      chk("shell_idx", 32'(hitBrickIdx), 32'd2);
      chk("shell_alive", 32'(brickAlive), 32'hFB);
      chk("shell_count", 32'(hitCount), 32'd1);

      // Dead brick 2 no longer counts
      pix(11'd200, 11'd60, 1'b0, 1'b1, 8'h04);
      sof();
      chk("dead_shell", 32'(shellHitBrick), 32'd0);
      tick();
      chk("dead_alive", 32'(brickAlive), 32'hFB);
      chk("dead_count", 32'(hitCount), 32'd1);
      chk("dead_idx_held", 32'(hitBrickIdx), 32'd2);

      // Off-screen overlaps ignored
      pix(11'd700, 11'd50, 1'b1, 1'b1, 8'h10);
      pix(11'd100, 11'd500, 1'b1, 1'b1, 8'h10);
      sof();
      chk("offscr_tank", 32'(tankHitBrick), 32'd0);
      chk("offscr_shell", 32'(shellHitBrick), 32'd0);
      tick();
      chk("offscr_alive", 32'(brickAlive), 32'hFB);

      // Shell on brick 0 with levelRestart in REPORT
      pix(11'd10, 11'd10, 1'b0, 1'b1, 8'h01);
      sof();
      chk("rst_lvl_pulse", 32'(shellHitBrick), 32'd1);
      levelRestart = 1'b1;
      tick();
      levelRestart = 1'b0;
      chk("rst_lvl_alive", 32'(brickAlive), 32'hFF);
      chk("rst_lvl_count", 32'(hitCount), 32'd0);

      // First shell hit in frame wins (brick 6, then brick 1)
      pix(11'd30, 11'd40, 1'b0, 1'b1, 8'h40);
      pix(11'd31, 11'd40, 1'b0, 1'b1, 8'h02);
      sof();
      chk("first_pulse", 32'(shellHitBrick), 32'd1);
      tick();
      chk("first_idx", 32'(hitBrickIdx), 32'd6);
      chk("first_alive", 32'(brickAlive), 32'hBF);
      chk("first_count", 32'(hitCount), 32'd1);

      // Reset mid-frame discards pending shell hit
      pix(11'd320, 11'd240, 1'b0, 1'b1, 8'h08);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("midrst_alive", 32'(brickAlive), 32'hFF);
      chk("midrst_count", 32'(hitCount), 32'd0);
      chk("midrst_idx", 32'(hitBrickIdx), 32'd0);
      sof();
      chk("midrst_idle_shell", 32'(shellHitBrick), 32'd0);
      tick();
      sof();
      chk("midrst_rep_shell", 32'(shellHitBrick), 32'd0);
      chk("midrst_rep_tank", 32'(tankHitBrick), 32'd0);
      tick();
      chk("midrst_alive2", 32'(brickAlive), 32'hFF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
